// File: rtl/hash_job_sched_pkg.sv
// Shared types and constants for the hash job scheduler.
package hash_sched_pkg;

  localparam int unsigned BASE_W     = 10;
  localparam int unsigned LEN_W      = 11;
  localparam int unsigned ID_W       = 4;
  localparam int unsigned CORE_AW    = 8;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CLR_CYCLES = 2;
  localparam int unsigned CLR_W      = $clog2(CLR_CYCLES);
  localparam int unsigned DIG_WORDS  = 8;
  localparam int unsigned HALF_WORDS = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    ABORT
  } state_e;

  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [ID_W-1:0]   id;
  } job_t;

  localparam int unsigned JOB_W = $bits(job_t);

endpackage

// File: rtl/hash_job_sched_if.sv
// Job request, hash core and digest stream signals of the scheduler.
interface hash_job_sched_if;
  import hash_sched_pkg::*;

  logic                job_valid;
  logic                job_ready;
  logic [BASE_W-1:0]   job_base;
  logic [LEN_W-1:0]    job_len;
  logic [ID_W-1:0]     job_id;
  logic                core_srst_n;
  logic                core_enable;
  logic [LEN_W-1:0]    core_m_len;
  logic [CORE_AW-1:0]  core_addr;
  logic [BASE_W-1:0]   sram_addr;
  logic                core_sha2_vld;
  logic                core_sha3_vld;
  logic [DATA_W-1:0]   core_data;
  logic                dig_valid;
  logic                dig_ready;
  logic [DATA_W-1:0]   dig_data;
  logic [IDX_W-1:0]    dig_idx;
  logic [ID_W-1:0]     dig_id;
  logic                dig_last;
  logic                err_timeout;

  // Scheduler side
  modport slave (
    input  job_valid, job_base, job_len, job_id,
    input  core_addr, core_sha2_vld, core_sha3_vld, core_data,
    input  dig_ready,
    output job_ready, core_srst_n, core_enable, core_m_len, sram_addr,
    output dig_valid, dig_data, dig_idx, dig_id, dig_last, err_timeout
  );

  // Environment side: job source, hash core and digest sink
  modport master (
    output job_valid, job_base, job_len, job_id,
    output core_addr, core_sha2_vld, core_sha3_vld, core_data,
    output dig_ready,
    input  job_ready, core_srst_n, core_enable, core_m_len, sram_addr,
    input  dig_valid, dig_data, dig_idx, dig_id, dig_last, err_timeout
  );

endinterface

// File: rtl/hash_job_sched_sync_fifo.sv
// Single-clock FIFO; pointers carry one wrap bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/hash_job_sched.sv
// Hash job scheduler: queues jobs, sequences the SHA2/SHA3 core per job,
// captures the 4+4 digest words and streams them downstream.
module hash_job_sched
  import hash_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4095
) (
  input logic             clk,
  input logic             srst_n,
  hash_job_sched_if.slave bus
);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_e              r_state;
  logic [CLR_W-1:0]    r_clr_cnt;
  logic [BASE_W-1:0]   r_act_base;
  logic [LEN_W-1:0]    r_act_len;
  logic [ID_W-1:0]     r_act_id;
  logic [CNT_W-1:0]    r_c2;
  logic [CNT_W-1:0]    r_c3;
  logic [TMR_W-1:0]    r_timer;
  logic [DATA_W-1:0]   r_buf [DIG_WORDS];
  logic                r_dig_valid;
  logic [IDX_W-1:0]    r_dig_idx;
  logic                r_dig_last;
  logic [DATA_W-1:0]   r_dig_data;
  logic                r_err_timeout;

  job_t                w_push_job;
  job_t                w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_cap2;
  logic                w_cap3;
  logic [CNT_W-1:0]    w_c2_nxt;
  logic [CNT_W-1:0]    w_c3_nxt;
  logic                w_done;
  logic                w_acc;
  logic                w_last_acc;

  assign w_push_job.base = bus.job_base;
  assign w_push_job.len  = bus.job_len;
  assign w_push_job.id   = bus.job_id;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_push = bus.job_valid && !w_full;

  sync_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst_n  (srst_n),
    .i_push  (w_push),
    .i_din   (w_push_job),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cap2     = (r_state == RUN) && bus.core_sha2_vld && (r_c2 != CNT_W'(HALF_WORDS));
  assign w_cap3     = (r_state == RUN) && bus.core_sha3_vld && (r_c3 != CNT_W'(HALF_WORDS));
  assign w_c2_nxt   = r_c2 + CNT_W'(w_cap2);
  assign w_c3_nxt   = r_c3 + CNT_W'(w_cap3);
  assign w_done     = (w_c2_nxt == CNT_W'(HALF_WORDS)) && (w_c3_nxt == CNT_W'(HALF_WORDS));
  assign w_acc      = r_dig_valid && bus.dig_ready;
  assign w_last_acc = w_acc && (r_dig_idx == IDX_W'(DIG_WORDS - 1));
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == DRAIN) && w_last_acc));

  // Digest buffer: SHA2 words fill slots 0-3, SHA3 words fill slots 4-7.
  always_ff @(posedge clk) begin
    if (w_cap2) r_buf[IDX_W'(r_c2)] <= bus.core_data;
    if (w_cap3) r_buf[IDX_W'(HALF_WORDS) + IDX_W'(r_c3)] <= bus.core_data;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state       <= IDLE;
      r_clr_cnt     <= '0;
      r_act_base    <= '0;
      r_act_len     <= '0;
      r_act_id      <= '0;
      r_c2          <= '0;
      r_c3          <= '0;
      r_timer       <= '0;
      r_dig_valid   <= 1'b0;
      r_dig_idx     <= '0;
      r_dig_last    <= 1'b0;
      r_dig_data    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_act_base <= w_head.base;
            r_act_len  <= w_head.len;
            r_act_id   <= w_head.id;
            r_clr_cnt  <= '0;
            r_state    <= CLR;
          end
        end
        CLR: begin
          r_c2    <= '0;
          r_c3    <= '0;
          r_timer <= '0;
          if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) r_state <= RUN;
          else r_clr_cnt <= r_clr_cnt + CLR_W'(1);
        end
        RUN: begin
          r_c2    <= w_c2_nxt;
          r_c3    <= w_c3_nxt;
          r_timer <= r_timer + TMR_W'(1);
          // Slot 0 is always written before the final capture, so it is safe to load here.
          if (w_done) begin
            r_state     <= DRAIN;
            r_dig_valid <= 1'b1;
            r_dig_idx   <= '0;
            r_dig_last  <= 1'b0;
            r_dig_data  <= r_buf[0];
          end else if (r_timer == TMR_W'(TIMEOUT)) begin
            r_state       <= ABORT;
            r_err_timeout <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_acc) begin
            if (w_last_acc) begin
              r_dig_valid <= 1'b0;
              r_dig_idx   <= '0;
              r_dig_last  <= 1'b0;
              if (!w_empty) begin
                r_act_base <= w_head.base;
                r_act_len  <= w_head.len;
                r_act_id   <= w_head.id;
                r_clr_cnt  <= '0;
                r_state    <= CLR;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_dig_idx  <= r_dig_idx + IDX_W'(1);
              r_dig_data <= r_buf[r_dig_idx + IDX_W'(1)];
              r_dig_last <= (r_dig_idx == IDX_W'(DIG_WORDS - 2));
            end
          end
        end
        ABORT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.job_ready   = !w_full;
  assign bus.core_srst_n = srst_n && (r_state != CLR);
  assign bus.core_enable = (r_state == RUN);
  assign bus.core_m_len  = r_act_len;
  assign bus.sram_addr   = r_act_base + BASE_W'(bus.core_addr);
  assign bus.dig_valid   = r_dig_valid;
  assign bus.dig_data    = r_dig_data;
  assign bus.dig_idx     = r_dig_idx;
  assign bus.dig_id      = r_act_id;
  assign bus.dig_last    = r_dig_last;
  assign bus.err_timeout = r_err_timeout;

endmodule
